// File: rtl/muldiv_unit_if.sv
// Decode-side bundle for the HI/LO multiply/divide unit.
// Decode drives the op request; the unit returns stall, busy and the HI/LO state.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rd_hilo_req;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, op_a, op_b, rd_hilo_req,
        input  stall, busy, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, op_a, op_b, rd_hilo_req,
        output stall, busy, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the MIPS HI/LO registers.
// Operands are reduced to magnitudes at accept; signs are reapplied in a single FIXUP cycle.
module muldiv_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int ITERS = 32 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t      state, state_next;
    logic [63:0] prod, mcand, prod_step;
    logic [31:0] mplier, rem, quot, divisor, rem_step, quot_step;
    logic [31:0] hi, lo, mag_a, mag_b;
    logic [32:0] shifted, trial;
    logic [5:0]  count;
    logic        neg_q, neg_r, is_div, dz;
    logic        busy, accept, is_signed, b_zero;

    assign busy      = (state != IDLE);
    assign accept    = bus.start & ~busy;
    assign is_signed = ~bus.op[0];
    assign b_zero    = (bus.op_b == 32'd0);
    assign mag_a     = (is_signed & bus.op_a[31]) ? -bus.op_a : bus.op_a;
    assign mag_b     = (is_signed & bus.op_b[31]) ? -bus.op_b : bus.op_b;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && bus.op[2:1] == 2'b00)
                    state_next = MUL;
                else if (accept && bus.op[2:1] == 2'b01 && !b_zero)
                    state_next = DIV;
            end
            MUL, DIV: if (count == 6'd1) state_next = FIXUP;
            FIXUP:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // One iteration's worth of multiplier bits and quotient bits, unrolled BITS_PER_CYCLE deep.
    always_comb begin
        prod_step = prod;
        rem_step  = rem;
        quot_step = quot;
        shifted   = '0;
        trial     = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier[k]) prod_step = prod_step + (mcand << k);
            shifted   = {rem_step, quot_step[31]};
            trial     = shifted - {1'b0, divisor};
            quot_step = {quot_step[30:0], ~trial[32]};
            rem_step  = trial[32] ? shifted[31:0] : trial[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
        end else begin
            dz <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !bus.op[2]) begin
                        neg_q   <= is_signed & (bus.op_a[31] ^ bus.op_b[31]);
                        neg_r   <= is_signed & bus.op_a[31];
                        count   <= 6'(ITERS);
                        is_div  <= bus.op[1];
                        prod    <= '0;
                        mcand   <= {32'd0, mag_a};
                        mplier  <= mag_b;
                        rem     <= '0;
                        quot    <= mag_a;
                        divisor <= mag_b;
                    end
                    if (accept) begin
                        case (bus.op)
                            3'b010, 3'b011: dz <= b_zero;
                            3'b100:         hi <= bus.op_a;
                            3'b101:         lo <= bus.op_a;
                            default:        ;
                        endcase
                    end
                end
                MUL: begin
                    prod   <= prod_step;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    count  <= count - 6'd1;
                end
                DIV: begin
                    rem   <= rem_step;
                    quot  <= quot_step;
                    count <= count - 6'd1;
                end
                FIXUP: begin
                    if (is_div) begin
                        lo <= neg_q ? -quot : quot;
                        hi <= neg_r ? -rem : rem;
                    end else begin
                        {hi, lo} <= neg_q ? -prod : prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall       = busy & (bus.start | bus.rd_hilo_req);
    assign bus.busy        = busy;
    assign bus.hi          = hi;
    assign bus.lo          = lo;
    assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: one instance per BITS_PER_CYCLE (1 and 4) sharing clock and reset,
// checked against an arithmetic HI/LO model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if if1 ();
    muldiv_unit_if if4 ();

    muldiv_unit #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    muldiv_unit #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    bit          cur;
    logic        start_d, rd_d;
    logic [2:0]  op_d;
    logic [31:0] a_d, b_d;

    assign if1.start       = start_d & ~cur;
    assign if4.start       = start_d & cur;
    assign if1.rd_hilo_req = rd_d & ~cur;
    assign if4.rd_hilo_req = rd_d & cur;
    assign if1.op = op_d;
    assign if4.op = op_d;
    assign if1.op_a = a_d;
    assign if4.op_a = a_d;
    assign if1.op_b = b_d;
    assign if4.op_b = b_d;

    wire        busy_c  = cur ? if4.busy : if1.busy;
    wire        stall_c = cur ? if4.stall : if1.stall;
    wire        dz_c    = cur ? if4.div_by_zero : if1.div_by_zero;
    wire [31:0] hi_c    = cur ? if4.hi : if1.hi;
    wire [31:0] lo_c    = cur ? if4.lo : if1.lo;

    int tests = 0;
    int fails = 0;
    logic [63:0] hilo_m [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input bit s);
        cur = s;
        #1;
    endtask

    function automatic int lat();
        return cur ? 9 : 33;
    endfunction

    // Architectural result of one op: {hi, lo} after it completes.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] prev);
        logic signed [63:0] sa, sb, sq, sr;
        logic [31:0] uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'd0: return sa * sb;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) return prev;
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'd3: begin
                if (b == 0) return prev;
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            3'd4: return {a, prev[31:0]};
            3'd5: return {prev[63:32], a};
            default: return prev;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd1) return lat();
        if ((op == 3'd2 || op == 3'd3) && b != 0) return lat();
        return 0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Presents one op, then counts busy cycles and div_by_zero pulses until idle (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int ndz);
        start_d = 1'b1; op_d = op; a_d = a; b_d = b;
        step();
        start_d = 1'b0;
        nbusy = 0;
        ndz = 0;
        for (int g = 0; g < 200; g++) begin
            ndz += int'(dz_c);
            if (!busy_c) break;
            nbusy++;
            step();
        end
        step();
        ndz += int'(dz_c);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_d = 1'b0; rd_d = 1'b0; op_d = '0; a_d = '0; b_d = '0;
        step(); step();
        for (int s = 0; s < 2; s++) begin
            set_cur(s[0]);
            tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_c); end
            tests++; if (hi_c !== 32'd0) begin fails++; $display("FAIL reset_hi[%0d]: got %h want 0", s, hi_c); end
            tests++; if (lo_c !== 32'd0) begin fails++; $display("FAIL reset_lo[%0d]: got %h want 0", s, lo_c); end
            tests++; if (dz_c !== 1'b0) begin fails++; $display("FAIL reset_dz[%0d]: got %b want 0", s, dz_c); end
        end
        rst = 1'b0;
        hilo_m[0] = '0;
        hilo_m[1] = '0;
        step();
        set_cur(1'b0);
        rd_d = 1'b1;
        #1;
        tests++; if (stall_c !== 1'b0) begin fails++; $display("FAIL idle_read_stall: got %b want 0", stall_c); end
        rd_d = 1'b0;
    endtask

    task automatic test_directed(input bit s);
        logic [2:0]  t_op [5];
        logic [31:0] t_a [5], t_b [5], t_hi [5], t_lo [5];
        int nb, nd;
        t_op = '{3'd0, 3'd3, 3'd2, 3'd2, 3'd1};
        t_a  = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
        t_b  = '{32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_hi = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE};
        t_lo = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'd1};
        set_cur(s);
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], nb, nd);
            tests++; if (nb != lat()) begin fails++; $display("FAIL dir_busy[%0d.%0d]: got %0d want %0d", s, i, nb, lat()); end
            tests++; if (nd != 0) begin fails++; $display("FAIL dir_dz[%0d.%0d]: got %0d want 0", s, i, nd); end
            tests++; if (hi_c !== t_hi[i]) begin fails++; $display("FAIL dir_hi[%0d.%0d]: got %h want %h", s, i, hi_c, t_hi[i]); end
            tests++; if (lo_c !== t_lo[i]) begin fails++; $display("FAIL dir_lo[%0d.%0d]: got %h want %h", s, i, lo_c, t_lo[i]); end
            hilo_m[s] = {t_hi[i], t_lo[i]};
        end
    endtask

    task automatic test_mthi_idle();
        set_cur(1'b0);
        start_d = 1'b1; op_d = 3'd4; a_d = 32'h1234_5678; b_d = '0;
        #1;
        tests++; if (stall_c !== 1'b0) begin fails++; $display("FAIL mthi_idle_stall: got %b want 0", stall_c); end
        step();
        start_d = 1'b0;
        hilo_m[0][63:32] = 32'h1234_5678;
        tests++; if (hi_c !== 32'h1234_5678) begin fails++; $display("FAIL mthi_idle_hi: got %h want 12345678", hi_c); end
        tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL mthi_idle_busy: got %b want 0", busy_c); end
        tests++; if (lo_c !== hilo_m[0][31:0]) begin fails++; $display("FAIL mthi_idle_lo: got %h want %h", lo_c, hilo_m[0][31:0]); end
    endtask

    task automatic test_div_by_zero(input bit s);
        int nb, nd;
        set_cur(s);
        run_op(3'd4, 32'hA5A5_A5A5, 32'd0, nb, nd);
        run_op(3'd5, 32'h5A5A_5A5A, 32'd0, nb, nd);
        hilo_m[s] = {32'hA5A5_A5A5, 32'h5A5A_5A5A};
        for (int i = 0; i < 2; i++) begin
            run_op(i == 0 ? 3'd2 : 3'd3, 32'd5, 32'd0, nb, nd);
            tests++; if (nb != 0) begin fails++; $display("FAIL dz_busy[%0d.%0d]: got %0d want 0", s, i, nb); end
            tests++; if (nd != 1) begin fails++; $display("FAIL dz_pulses[%0d.%0d]: got %0d want 1", s, i, nd); end
            tests++; if ({hi_c, lo_c} !== 64'hA5A5_A5A5_5A5A_5A5A) begin
                fails++; $display("FAIL dz_hilo[%0d.%0d]: got %h want a5a5a5a55a5a5a5a", s, i, {hi_c, lo_c});
            end
        end
    endtask

    task automatic test_stall_read();
        int nst, nb;
        set_cur(1'b0);
        start_d = 1'b1; op_d = 3'd1; a_d = 32'hFFFF_FFFF; b_d = 32'hFFFF_FFFF;
        step();
        start_d = 1'b0;
        rd_d = 1'b1;
        nst = 0;
        nb = 0;
        for (int g = 0; g < 200; g++) begin
            if (!busy_c) break;
            nb++;
            nst += int'(stall_c);
            step();
        end
        tests++; if (nst != 33 || nb != 33) begin fails++; $display("FAIL read_stall_cycles: got stall %0d busy %0d want 33", nst, nb); end
        tests++; if (stall_c !== 1'b0) begin fails++; $display("FAIL read_stall_release: got %b want 0", stall_c); end
        tests++; if (lo_c !== 32'd1) begin fails++; $display("FAIL mflo_data: got %h want 00000001", lo_c); end
        tests++; if (hi_c !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mfhi_data: got %h want fffffffe", hi_c); end
        rd_d = 1'b0;
        hilo_m[0] = {32'hFFFF_FFFE, 32'd1};
    endtask

    task automatic test_ignored(input bit s);
        set_cur(s);
        for (int i = 6; i < 8; i++) begin
            start_d = 1'b1; op_d = 3'(i); a_d = $urandom; b_d = $urandom;
            #1;
            tests++; if (stall_c !== 1'b0) begin fails++; $display("FAIL ign_stall[%0d]: got %b want 0", i, stall_c); end
            step();
            start_d = 1'b0;
            tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL ign_busy[%0d]: got %b want 0", i, busy_c); end
            tests++; if ({hi_c, lo_c} !== hilo_m[s]) begin fails++; $display("FAIL ign_hilo[%0d]: got %h want %h", i, {hi_c, lo_c}, hilo_m[s]); end
        end
    endtask

    // First op runs; second is held on start throughout and must wait for the first.
    task automatic test_back_to_back(input bit s, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                     input logic [2:0] op2, input logic [31:0] a2, input logic [31:0] b2);
        logic [63:0] e1, e2;
        int nb, nbad, n2;
        set_cur(s);
        e1 = model(op1, a1, b1, hilo_m[s]);
        e2 = model(op2, a2, b2, e1);
        start_d = 1'b1; op_d = op1; a_d = a1; b_d = b1;
        step();
        op_d = op2; a_d = a2; b_d = b2;
        nb = 0;
        nbad = 0;
        for (int g = 0; g < 200; g++) begin
            if (!busy_c) break;
            if (stall_c !== 1'b1) nbad++;
            nb++;
            step();
        end
        tests++; if (nb != lat() || nbad != 0) begin fails++; $display("FAIL b2b_first[%0d]: busy %0d unstalled %0d want %0d/0", s, nb, nbad, lat()); end
        tests++; if ({hi_c, lo_c} !== e1) begin fails++; $display("FAIL b2b_first_hilo[%0d]: got %h want %h", s, {hi_c, lo_c}, e1); end
        tests++; if (stall_c !== 1'b0) begin fails++; $display("FAIL b2b_idle_stall[%0d]: got %b want 0", s, stall_c); end
        step();
        start_d = 1'b0;
        n2 = 0;
        for (int g = 0; g < 200; g++) begin
            if (!busy_c) break;
            n2++;
            step();
        end
        tests++; if (n2 != exp_busy(op2, b2)) begin fails++; $display("FAIL b2b_second_busy[%0d]: got %0d want %0d", s, n2, exp_busy(op2, b2)); end
        tests++; if ({hi_c, lo_c} !== e2) begin fails++; $display("FAIL b2b_second_hilo[%0d]: got %h want %h", s, {hi_c, lo_c}, e2); end
        hilo_m[s] = e2;
    endtask

    task automatic test_rst_mid(input bit s, input int iters);
        int nb, nd;
        set_cur(s);
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, nb, nd);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, nb, nd);
        start_d = 1'b1; op_d = 3'd2; a_d = $urandom; b_d = $urandom | 32'd1;
        step();
        start_d = 1'b0;
        repeat (iters) step();
        tests++; if (busy_c !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before[%0d]: got %b want 1", s, busy_c); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        hilo_m[0] = '0;
        hilo_m[1] = '0;
        tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL rst_mid_busy[%0d]: got %b want 0", s, busy_c); end
        tests++; if ({hi_c, lo_c} !== 64'd0) begin fails++; $display("FAIL rst_mid_hilo[%0d]: got %h want 0", s, {hi_c, lo_c}); end
        repeat (40) step();
        tests++; if ({hi_c, lo_c} !== 64'd0 || busy_c !== 1'b0) begin
            fails++; $display("FAIL rst_mid_no_fixup[%0d]: got %h busy %b want 0", s, {hi_c, lo_c}, busy_c);
        end
    endtask

    task automatic test_random(input bit s, input int n);
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        int nb, nd, edz;
        set_cur(s);
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            e = model(op, a, b, hilo_m[s]);
            edz = ((op == 3'd2 || op == 3'd3) && b == 0) ? 1 : 0;
            run_op(op, a, b, nb, nd);
            tests++; if (nb != exp_busy(op, b)) begin fails++; $display("FAIL rand_busy[%0d.%0d] op%0d: got %0d want %0d", s, i, op, nb, exp_busy(op, b)); end
            tests++; if (nd != edz) begin fails++; $display("FAIL rand_dz[%0d.%0d] op%0d: got %0d want %0d", s, i, op, nd, edz); end
            tests++; if ({hi_c, lo_c} !== e) begin
                fails++; $display("FAIL rand_hilo[%0d.%0d] op%0d a=%h b=%h: got %h want %h", s, i, op, a, b, {hi_c, lo_c}, e);
            end
            hilo_m[s] = e;
        end
    endtask

    initial begin
        test_reset();
        test_directed(1'b0);
        test_mthi_idle();
        test_div_by_zero(1'b0);
        test_stall_read();
        test_ignored(1'b0);
        test_back_to_back(1'b0, 3'd0, $urandom, $urandom, 3'd4, 32'h1234_5678, 32'd0);
        test_back_to_back(1'b0, 3'd2, $urandom, $urandom | 32'd1, 3'd1, $urandom, $urandom);
        test_random(1'b0, 25);
        test_rst_mid(1'b0, 10);
        test_directed(1'b1);
        test_div_by_zero(1'b1);
        test_ignored(1'b1);
        test_back_to_back(1'b1, 3'd1, $urandom, $urandom, 3'd3, $urandom, $urandom | 32'd1);
        test_random(1'b1, 25);
        test_rst_mid(1'b1, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
